turn_signal_ctrl_param: RTL

//  Next-generation turn/hazard indicator controller for the car top level. Drives left/right

---
 rtl/turn_signal_ctrl_param_pkg.sv | 17 +
 rtl/turn_signal_ctrl_param_blink_tick_gen.sv | 41 ++++
 rtl/turn_signal_ctrl_param.sv | 98 +++++++++
 3 files changed

// File: rtl/turn_signal_ctrl_param_pkg.sv
// Shared car-level encodings: one-hot car states and indicator mode codes.
// Reused by the turn-signal, display and buzzer blocks.
package turn_signal_ctrl_param_pkg;

    localparam logic [3:0] ST_IDLE     = 4'b0001;
    localparam logic [3:0] ST_STARTING = 4'b0010;
    localparam logic [3:0] ST_MOVING   = 4'b0100;
    localparam logic [3:0] ST_POWEROFF = 4'b1000;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_LEFT   = 2'b01,
        MODE_RIGHT  = 2'b10,
        MODE_HAZARD = 2'b11
    } mode_t;

endpackage

// File: rtl/turn_signal_ctrl_param_blink_tick_gen.sv
// Blink phase generator: a half-period counter that toggles phase on every wrap,
// with a restart that forces the ON phase from a fresh count.
module blink_tick_gen #(
    parameter int HALF  = 5,
    parameter int CNT_W = (HALF > 1) ? $clog2(HALF) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic restart,
    output logic phase,
    output logic off_edge
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF - 1);

    logic [CNT_W-1:0] cnt;
    logic             wrap;

    assign wrap     = run && (cnt == LAST);
    // Flags the ON->OFF transition in the cycle before it becomes visible.
    assign off_edge = wrap && phase;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (restart) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (run) begin
            if (wrap) begin
                cnt   <= '0;
                phase <= ~phase;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/turn_signal_ctrl_param.sv
// Turn/hazard indicator controller: mode FSM with lane-change flash tail,
// driving left/right lamps from a single-clock blink phase generator.
module turn_signal_ctrl_param
    import turn_signal_ctrl_param_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BLINK_HZ    = 2,
    parameter int MIN_FLASHES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       power_now,
    input  logic [3:0] state,
    input  logic       turn_left,
    input  logic       turn_right,
    input  logic       hazard_req,
    output logic       left_led,
    output logic       right_led,
    output logic [1:0] mode
);

    localparam int HALF  = CLK_FREQ_HZ / (2 * BLINK_HZ);
    localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int FL_W  = (MIN_FLASHES > 0) ? $clog2(MIN_FLASHES + 1) : 1;
    localparam logic [FL_W-1:0] FL_MAX = FL_W'(MIN_FLASHES);

    mode_t            cur_mode, nxt_mode, req;
    logic [FL_W-1:0]  flash_cnt, flash_inc, flash_nxt;
    logic             turn_ok, haz_ok, mode_chg, run;
    logic             phase, off_edge;

    blink_tick_gen #(
        .HALF  (HALF),
        .CNT_W (CNT_W)
    ) u_tick (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .restart  (mode_chg),
        .phase    (phase),
        .off_edge (off_edge)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_mode  <= MODE_OFF;
            flash_cnt <= '0;
        end else begin
            cur_mode  <= nxt_mode;
            flash_cnt <= flash_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        turn_ok = power_now && (state == ST_STARTING || state == ST_MOVING);
        haz_ok  = power_now && (state != ST_POWEROFF);

        req = MODE_OFF;
        if (hazard_req && haz_ok)
            req = MODE_HAZARD;
        else if (turn_ok && (turn_left ^ turn_right))
            req = turn_left ? MODE_LEFT : MODE_RIGHT;

        // A flash completing this cycle counts before the tail exit is judged.
        flash_inc = (off_edge && flash_cnt != FL_MAX) ? flash_cnt + 1'b1 : flash_cnt;

        nxt_mode = cur_mode;
        if (!haz_ok) begin
            nxt_mode = MODE_OFF;
        end else begin
            unique case (cur_mode)
                MODE_OFF:    nxt_mode = req;
                MODE_HAZARD: nxt_mode = req;
                default: begin
                    if (req != MODE_OFF)
                        nxt_mode = req;
                    else if (!turn_ok)
                        nxt_mode = MODE_OFF;
                    else if (flash_inc >= FL_MAX)
                        nxt_mode = MODE_OFF;
                end
            endcase
        end
    end

    // Output logic
    always_comb begin
        mode_chg  = (nxt_mode != cur_mode);
        run       = (cur_mode != MODE_OFF);
        flash_nxt = mode_chg ? '0 : flash_inc;
        mode      = cur_mode;
        left_led  = phase && (cur_mode == MODE_LEFT  || cur_mode == MODE_HAZARD);
        right_led = phase && (cur_mode == MODE_RIGHT || cur_mode == MODE_HAZARD);
    end

endmodule
